// File: rtl/servo_cmd_if.sv
// Command handshake bundle for servo_angle_ramp.
// Unsigned command value and channel index, valid/ready flow control.
interface servo_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ch;
    logic [31:0] cmd_value;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_value,
        output cmd_ready
    );
endinterface

// File: rtl/servo_angle_ramp.sv
// Multi-channel servo angle generator: clamped command targets, optional slew.
// Define SERVO_RAMP_EN for 1-degree-per-tick ramping; otherwise angle follows target.
module servo_angle_ramp #(
    parameter int CHANNELS    = 4,
    parameter int STEP_DEG    = 10,
    parameter int MAX_ANGLE   = 180,
    parameter int ANGLE_W     = 9,
    parameter int RAMP_DIV    = 100000,
    parameter int RESET_ANGLE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    servo_cmd_if.slave                  cmd,
    output logic [CHANNELS*ANGLE_W-1:0] angle,
    output logic [CHANNELS-1:0]         busy,
    output logic                        err
);

    if (RAMP_DIV < 2 || CHANNELS < 1 || CHANNELS > 8 ||
        RESET_ANGLE > MAX_ANGLE || MAX_ANGLE >= (1 << ANGLE_W)) begin : g_bad_param
        $error("servo_angle_ramp: illegal parameter combination");
    end

    logic                s1_valid_q, s1_valid_d;
    logic [2:0]          s1_ch_q, s1_ch_d;
    logic [31:0]         s1_value_q, s1_value_d;
    logic [ANGLE_W-1:0]  target_q [CHANNELS];
    logic [ANGLE_W-1:0]  target_d [CHANNELS];
    logic [ANGLE_W-1:0]  angle_q  [CHANNELS];
    logic [ANGLE_W-1:0]  angle_d  [CHANNELS];
    logic [CHANNELS-1:0] busy_q, busy_d;
    logic                err_q, err_d;
    logic [39:0]         product;
    logic                ch_bad;
    logic                clamp;
    logic                accept;

    assign cmd.cmd_ready = !s1_valid_q && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        s1_valid_d = accept;
        s1_ch_d    = s1_ch_q;
        s1_value_d = s1_value_q;
        if (accept) begin
            s1_ch_d    = cmd.cmd_ch;
            s1_value_d = cmd.cmd_value;
        end
    end

    // 40-bit product so a full-scale 32-bit value can never wrap under the clamp
    always_comb begin
        product = 40'(s1_value_q) * 40'(STEP_DEG);
        ch_bad  = {1'b0, s1_ch_q} >= 4'(CHANNELS);
        clamp   = product > 40'(MAX_ANGLE);
        err_d   = s1_valid_q && (ch_bad || clamp);
        for (int n = 0; n < CHANNELS; n++) begin
            target_d[n] = target_q[n];
            if (s1_valid_q && !ch_bad && {1'b0, s1_ch_q} == 4'(n)) begin
                target_d[n] = clamp ? ANGLE_W'(MAX_ANGLE)
                                    : product[ANGLE_W-1:0];
            end
        end
    end

`ifdef SERVO_RAMP_EN
    localparam int CNT_W = $clog2(RAMP_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // Steps compare against the pre-write target; a same-cycle write lands next tick
    always_comb begin
        tick  = cnt_q == CNT_W'(RAMP_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        for (int n = 0; n < CHANNELS; n++) begin
            angle_d[n] = angle_q[n];
            busy_d[n]  = angle_q[n] != target_q[n];
            if (tick && angle_q[n] < target_q[n]) begin
                angle_d[n] = angle_q[n] + ANGLE_W'(1);
            end else if (tick && angle_q[n] > target_q[n]) begin
                angle_d[n] = angle_q[n] - ANGLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        busy_d = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            angle_d[n] = target_q[n];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_value_q <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                target_q[n] <= ANGLE_W'(RESET_ANGLE);
                angle_q[n]  <= ANGLE_W'(RESET_ANGLE);
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_value_q <= s1_value_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            for (int n = 0; n < CHANNELS; n++) begin
                target_q[n] <= target_d[n];
                angle_q[n]  <= angle_d[n];
            end
        end
    end

    always_comb begin
        angle = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            angle[n*ANGLE_W +: ANGLE_W] = angle_q[n];
        end
    end

    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp: handshake, clamp, bad channel, reset.
// Angle timing checks follow whichever SERVO_RAMP_EN build is compiled.
module tb_servo_angle_ramp;

    localparam int CH = 4;
    localparam int AW = 9;
    localparam int RD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH*AW-1:0] angle;
    logic [CH-1:0]   busy;
    logic            err;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              max_jump = 0;

    servo_cmd_if cmd ();

    servo_angle_ramp #(
        .CHANNELS    (CH),
        .STEP_DEG    (10),
        .MAX_ANGLE   (180),
        .ANGLE_W     (AW),
        .RAMP_DIV    (RD),
        .RESET_ANGLE (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cmd.slave),
        .angle (angle),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ang(input int n);
        return int'(angle[n*AW +: AW]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after edge E+1, where err for the command is visible
    task automatic send(input logic [2:0] ch, input logic [31:0] v);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_ch    = ch;
        cmd.cmd_value = v;
        #1;
        check("ready_at_send", cmd.cmd_ready, 1);
        step();
        cmd.cmd_valid = 1'b0;
        step();
    endtask

    task automatic wait_ang(input string tag, input int n, input int tgt,
                            input int budget);
        int prev;
        int d;
        prev = ang(n);
        for (int i = 0; i < budget && ang(n) != tgt; i++) begin
            step();
            d = ang(n) - prev;
            if (d < 0) d = -d;
            if (d > max_jump) max_jump = d;
            prev = ang(n);
        end
        check(tag, ang(n), tgt);
    endtask

    initial begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_ch    = '0;
        cmd.cmd_value = '0;

        rst = 1'b1;
        repeat (3) step();
        check("ready_in_rst", cmd.cmd_ready, 0);
        check("rst_angle", angle, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd.cmd_ready, 1);
        step();

`ifdef SERVO_RAMP_EN
        send(3'd0, 32'd3);
        check("ramp_err", err, 0);
        step();
        check("ramp_busy_rise", busy[0], 1);
        wait_ang("ramp_reach30", 0, 30, 30 * RD + RD + 4);
        step();
        check("ramp_busy_fall", busy[0], 0);

        send(3'd2, 32'd9);
        wait_ang("retgt_reach50", 2, 50, 50 * RD + RD + 4);
        send(3'd2, 32'd2);
        wait_ang("retgt_reach20", 2, 20, 40 * RD + RD + 4);
        check("retgt_no_jump", max_jump, 1);
`else
        send(3'd3, 32'd9);
        check("ch3_err", err, 0);
        check("ch3_angle_e1", ang(3), 0);
        step();
        check("ch3_angle_e2", ang(3), 90);
        check("ch3_busy", busy, 0);
`endif

        send(3'd1, 32'd25);
        check("clamp_err", err, 1);
        step();
        check("clamp_err_one", err, 0);
`ifndef SERVO_RAMP_EN
        check("clamp_angle", ang(1), 180);
`endif

        send(3'd0, 32'hFFFF_FFFF);
        check("wide_err", err, 1);
        step();
`ifndef SERVO_RAMP_EN
        check("wide_angle", ang(0), 180);
        send(3'd0, 32'd0);
        check("zero_err", err, 0);
        step();
        check("zero_angle", ang(0), 0);
`endif

        send(3'd5, 32'd1);
        check("badch_err", err, 1);
        step();
`ifndef SERVO_RAMP_EN
        check("badch_angle0", ang(0), 0);
        check("badch_angle1", ang(1), 180);
        check("badch_angle2", ang(2), 0);
        check("badch_angle3", ang(3), 90);
`endif

        send(3'd2, 32'd18);
        check("max_exact_err", err, 0);
        send(3'd2, 32'd19);
        check("max_plus1_err", err, 1);
        step();
`ifndef SERVO_RAMP_EN
        check("max_plus1_angle", ang(2), 180);
`endif

        cmd.cmd_valid = 1'b1;
        cmd.cmd_ch    = 3'd2;
        cmd.cmd_value = 32'd5;
        for (int i = 0; i < 4; i++) begin
            check("b2b_ready", cmd.cmd_ready, (i % 2 == 0) ? 1 : 0);
            step();
        end
        cmd.cmd_valid = 1'b0;
        step();
        step();
`ifndef SERVO_RAMP_EN
        check("b2b_angle", ang(2), 50);
`endif

        cmd.cmd_valid = 1'b1;
        cmd.cmd_ch    = 3'd3;
        cmd.cmd_value = 32'd1;
        step();
        cmd.cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("midrst_angle", angle, 0);
        check("midrst_ready", cmd.cmd_ready, 0);
        rst = 1'b0;
        step();
        step();
        check("midrst_lost", ang(3), 0);
        check("midrst_err", err, 0);
        check("midrst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
